// File: rtl/lab5_fetch_unit.sv
// Instruction fetch stage: PC register, one-word instruction latch, branch redirect with flush.
// Optional macro FETCH_HALT_EN turns a fetched 0x0000 word into a halt.
module lab5_fetch_unit (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [7:0]  BR_OFFSET,
    input  logic [15:0] Q_IN,
    output logic [7:0]  ADDR,
    output logic [15:0] INSTR,
    output logic [7:0]  INSTR_PC,
    output logic        INSTR_VALID,
    output logic        HALTED,
    output logic [15:0] FETCH_CNT
);

    typedef enum logic [1:0] {WAIT, RUN, HALT} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [15:0] instr_reg, instr_next;
    logic [7:0]  instr_pc_reg, instr_pc_next;
    logic        valid_reg, valid_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        halt_word;
    logic [7:0]  br_target;

`ifdef FETCH_HALT_EN
    assign halt_word = (Q_IN == 16'h0000);
    assign HALTED    = (state_reg == HALT);
`else
    assign halt_word = 1'b0;
    assign HALTED    = 1'b0;
`endif

    // Adding the offset as an unsigned byte gives the same result as a signed add modulo 256.
    assign br_target = (instr_pc_reg + 8'd2 + BR_OFFSET) & 8'hFE;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg    <= WAIT;
            pc_reg       <= 8'h00;
            instr_reg    <= 16'h0000;
            instr_pc_reg <= 8'h00;
            valid_reg    <= 1'b0;
            cnt_reg      <= 16'h0000;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            valid_reg    <= valid_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        valid_next    = valid_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            WAIT: begin
                state_next = RUN;
                valid_next = 1'b0;
            end
            RUN: begin
                if (!STALL) begin
                    if (BR_TAKEN && valid_reg) begin
                        // Redirect and squash the wrong-path word presented this cycle.
                        pc_next    = br_target;
                        valid_next = 1'b0;
                    end else if (halt_word) begin
                        state_next = HALT;
                        valid_next = 1'b0;
                    end else begin
                        instr_next    = Q_IN;
                        instr_pc_next = pc_reg;
                        valid_next    = 1'b1;
                        pc_next       = pc_reg + 8'd2;
                        if (cnt_reg != 16'hFFFF)
                            cnt_next = cnt_reg + 16'd1;
                    end
                end
            end
            HALT: begin
                valid_next = 1'b0;
            end
            default: begin
                state_next = WAIT;
                valid_next = 1'b0;
            end
        endcase
    end

    assign ADDR        = pc_reg;
    assign INSTR       = instr_reg;
    assign INSTR_PC    = instr_pc_reg;
    assign INSTR_VALID = valid_reg;
    assign FETCH_CNT   = cnt_reg;

endmodule

// File: tb/tb_lab5_fetch_unit.sv
// Self-checking bench for lab5_fetch_unit: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the fetch rules.
module tb_lab5_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        STALL;
    logic        BR_TAKEN;
    logic [7:0]  BR_OFFSET;
    logic [15:0] Q_IN;
    logic [7:0]  ADDR;
    logic [15:0] INSTR;
    logic [7:0]  INSTR_PC;
    logic        INSTR_VALID;
    logic        HALTED;
    logic [15:0] FETCH_CNT;

    logic [15:0] mem [0:127];

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: mode 0 = waiting, 1 = running, 2 = halted
    int          m_mode;
    int          m_pc;
    int          m_ipc;
    int          m_cnt;
    logic [15:0] m_instr;
    bit          m_valid;

    always #5 CLK = ~CLK;

    assign Q_IN = mem[ADDR[7:1]];

    lab5_fetch_unit dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .STALL      (STALL),
        .BR_TAKEN   (BR_TAKEN),
        .BR_OFFSET  (BR_OFFSET),
        .Q_IN       (Q_IN),
        .ADDR       (ADDR),
        .INSTR      (INSTR),
        .INSTR_PC   (INSTR_PC),
        .INSTR_VALID(INSTR_VALID),
        .HALTED     (HALTED),
        .FETCH_CNT  (FETCH_CNT)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit stall, input bit br, input logic [7:0] off);
        int tgt;
        logic [15:0] word;
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_ipc = 0; m_cnt = 0; m_instr = 16'h0000; m_valid = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && !stall) begin
            word = mem[m_pc / 2];
            if (br && m_valid) begin
                tgt     = m_ipc + 2 + ((off >= 128) ? int'(off) - 256 : int'(off));
                m_pc    = ((tgt % 256 + 256) % 256) / 2 * 2;
                m_valid = 0;
            end else if (HALT_EN && word == 16'h0000) begin
                m_mode  = 2;
                m_valid = 0;
            end else begin
                m_instr = word;
                m_ipc   = m_pc;
                m_valid = 1;
                m_pc    = (m_pc + 2) % 256;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic cycle(input bit rst_n, input bit stall, input bit br, input logic [7:0] off);
        RESET_N   = rst_n;
        STALL     = stall;
        BR_TAKEN  = br;
        BR_OFFSET = off;
        model_step(rst_n, stall, br, off);
        @(posedge CLK);
        #1;
        chk("addr",   {8'h00, ADDR},        16'(m_pc));
        chk("instr",  INSTR,                m_instr);
        chk("ipc",    {8'h00, INSTR_PC},    16'(m_ipc));
        chk("valid",  {15'h0, INSTR_VALID}, {15'h0, m_valid});
        chk("halted", {15'h0, HALTED},      {15'h0, (m_mode == 2)});
        chk("cnt",    FETCH_CNT,            16'(m_cnt));
        $display("t=%0t rst_n=%0b stall=%0b br=%0b off=%h -> addr=%h instr=%h ipc=%h v=%0b h=%0b cnt=%0d",
                 $time, rst_n, stall, br, off, ADDR, INSTR, INSTR_PC, INSTR_VALID, HALTED, FETCH_CNT);
    endtask

    initial begin
        logic [7:0]  s_addr, s_ipc, off;
        logic [15:0] s_instr, s_cnt;
        logic        s_valid;

        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom_range(1, 65535));
        RESET_N = 1'b0; STALL = 1'b0; BR_TAKEN = 1'b0; BR_OFFSET = 8'h00;

        // Reset with noisy control inputs
        cycle(0, 1, 1, 8'h55);
        cycle(0, 0, 1, 8'hAA);
        chk("rst_addr", {8'h00, ADDR}, 16'h0000);
        chk("rst_cnt", FETCH_CNT, 16'h0000);

        // Release: WAIT cycle with no fetch, then sequential fetches
        cycle(1, 0, 0, 8'h00);
        chk("wait_addr", {8'h00, ADDR}, 16'h0000);
        chk("wait_valid", {15'h0, INSTR_VALID}, 16'h0000);
        cycle(1, 0, 0, 8'h00);
        chk("first_instr", INSTR, mem[0]);
        chk("first_ipc", {8'h00, INSTR_PC}, 16'h0000);
        cycle(1, 0, 0, 8'h00);
        chk("second_instr", INSTR, mem[1]);
        chk("second_ipc", {8'h00, INSTR_PC}, 16'h0002);
        chk("second_cnt", FETCH_CNT, 16'd2);
        for (int i = 0; i < 14; i++) cycle(1, 0, 0, 8'h00);
        chk("pre_br_ipc", {8'h00, INSTR_PC}, 16'h001E);

        // Backward branch from 0x1E by -16
        cycle(1, 0, 1, 8'hF0);
        chk("br_valid", {15'h0, INSTR_VALID}, 16'h0000);
        chk("br_addr", {8'h00, ADDR}, 16'h0010);
        chk("br_hold_ipc", {8'h00, INSTR_PC}, 16'h001E);
        cycle(1, 0, 0, 8'h00);
        chk("br_target_ipc", {8'h00, INSTR_PC}, 16'h0010);

        // Stall holds everything and swallows branch pulses
        s_addr = ADDR; s_ipc = INSTR_PC; s_instr = INSTR; s_cnt = FETCH_CNT; s_valid = INSTR_VALID;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 8'($urandom));
            chk("stall_addr", {8'h00, ADDR}, {8'h00, s_addr});
            chk("stall_instr", INSTR, s_instr);
            chk("stall_cnt", FETCH_CNT, s_cnt);
            chk("stall_valid", {15'h0, INSTR_VALID}, {15'h0, s_valid});
        end
        cycle(1, 0, 0, 8'h00);
        chk("post_stall_ipc", {8'h00, INSTR_PC}, {8'h00, s_addr});
        chk("post_stall_addr", {8'h00, ADDR}, {8'h00, 8'(s_addr + 8'd2)});

        // Branch to 0xFE and fetch across the wrap
        off = 8'hFE - INSTR_PC - 8'd2;
        cycle(1, 0, 1, off);
        chk("to_fe_addr", {8'h00, ADDR}, 16'h00FE);
        cycle(1, 0, 0, 8'h00);
        chk("wrap_ipc", {8'h00, INSTR_PC}, 16'h00FE);
        chk("wrap_addr", {8'h00, ADDR}, 16'h0000);

        // Zero word at 0x92
        mem[8'h92 >> 1] = 16'h0000;
        off = 8'h92 - INSTR_PC - 8'd2;
        cycle(1, 0, 1, off);
        cycle(1, 0, 0, 8'h00);
        if (HALT_EN) begin
            chk("halt_flag", {15'h0, HALTED}, 16'h0001);
            chk("halt_addr", {8'h00, ADDR}, 16'h0092);
            chk("halt_valid", {15'h0, INSTR_VALID}, 16'h0000);
        end else begin
            chk("zero_instr", INSTR, 16'h0000);
            chk("zero_ipc", {8'h00, INSTR_PC}, 16'h0092);
            chk("zero_addr", {8'h00, ADDR}, 16'h0094);
        end
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'($urandom));

        // Reset overrides stall and branch, from halt or running state
        cycle(0, 1, 1, 8'h10);
        chk("rst2_addr", {8'h00, ADDR}, 16'h0000);
        chk("rst2_cnt", FETCH_CNT, 16'h0000);
        chk("rst2_halted", {15'h0, HALTED}, 16'h0000);
        cycle(1, 0, 0, 8'h00);
        chk("rst2_wait_valid", {15'h0, INSTR_VALID}, 16'h0000);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 1, 8'h20);
        chk("rst3_addr", {8'h00, ADDR}, 16'h0000);
        chk("rst3_cnt", FETCH_CNT, 16'h0000);

        // Random traffic against the model
        for (int i = 0; i < 128; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), 8'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
